// File: rtl/dram_arbiter_if.sv
// Requester-side request/response bundle for one port of the data RAM arbiter.
interface dram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dram_arbiter.sv
// Round-robin two-port arbiter in front of a single-port byte-writable data RAM;
// handles lane placement for stores and extension/alignment checks for loads.
module dram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  dram_arbiter_if.slave           p0,
  dram_arbiter_if.slave           p1,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic                    mem_wr_en,
  output logic [DATA_WIDTH/8-1:0] mem_wr_byte_en,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data
);
  localparam int unsigned BAW = ADDR_WIDTH + 2;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       port;
    logic       we;
    logic [1:0] off;
    logic [1:0] size;
    logic       uns;
    logic       err;
  } rsp_pipe_t;

  logic            prio;
  logic            gnt0, gnt1, any_gnt;
  logic            sel_we, sel_uns, sel_err;
  logic [BAW-1:0]  sel_addr;
  logic [1:0]      sel_size;
  logic [31:0]     sel_wdata;
  rsp_pipe_t       pipe;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [31:0]     rd_ext;
  logic            hit0, hit1;

  // Grant: lone requester wins; on contention the port equal to prio wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (p0.req_valid && (!p1.req_valid || !prio)) gnt0 = 1'b1;
      else if (p1.req_valid)                        gnt1 = 1'b1;
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign sel_we    = gnt1 ? p1.req_we       : p0.req_we;
  assign sel_addr  = gnt1 ? p1.req_addr     : p0.req_addr;
  assign sel_size  = gnt1 ? p1.req_size     : p0.req_size;
  assign sel_uns   = gnt1 ? p1.req_unsigned : p0.req_unsigned;
  assign sel_wdata = gnt1 ? p1.req_wdata    : p0.req_wdata;

  always_comb begin
    sel_err = 1'b0;
    case (sel_size)
      SZ_BYTE: sel_err = 1'b0;
      SZ_HALF: sel_err = sel_addr[0];
      SZ_WORD: sel_err = |sel_addr[1:0];
      default: sel_err = 1'b1;
    endcase
  end

  // RAM drive; error and idle cycles leave the bus at zero.
  always_comb begin
    mem_addr       = '0;
    mem_wr_data    = '0;
    mem_wr_en      = 1'b0;
    mem_wr_byte_en = '0;
    if (any_gnt && !sel_err) begin
      mem_addr = sel_addr[BAW-1:2];
      if (sel_we) begin
        mem_wr_en = 1'b1;
        case (sel_size)
          SZ_BYTE: begin
            mem_wr_byte_en = 4'b0001 << sel_addr[1:0];
            mem_wr_data    = {24'h0, sel_wdata[7:0]} << {sel_addr[1:0], 3'b000};
          end
          SZ_HALF: begin
            mem_wr_byte_en = sel_addr[1] ? 4'b1100 : 4'b0011;
            mem_wr_data    = sel_addr[1] ? {sel_wdata[15:0], 16'h0}
                                         : {16'h0, sel_wdata[15:0]};
          end
          default: begin
            mem_wr_byte_en = 4'b1111;
            mem_wr_data    = sel_wdata;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
      pipe <= '0;
    end else begin
      pipe.valid <= any_gnt;
      pipe.port  <= gnt1;
      pipe.we    <= sel_we;
      pipe.off   <= sel_addr[1:0];
      pipe.size  <= sel_size;
      pipe.uns   <= sel_uns;
      pipe.err   <= sel_err;
      if (any_gnt) prio <= gnt0;
    end
  end

  // Load data is picked from the RAM output in the response cycle.
  always_comb begin
    rd_byte = mem_rd_data[{pipe.off, 3'b000} +: 8];
    rd_half = pipe.off[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
    case (pipe.size)
      SZ_BYTE: rd_ext = {{24{rd_byte[7] & ~pipe.uns}}, rd_byte};
      SZ_HALF: rd_ext = {{16{rd_half[15] & ~pipe.uns}}, rd_half};
      default: rd_ext = mem_rd_data;
    endcase
    if (pipe.we || pipe.err) rd_ext = '0;
  end

  assign hit0 = pipe.valid & ~pipe.port;
  assign hit1 = pipe.valid &  pipe.port;

  assign p0.req_ready = gnt0;
  assign p1.req_ready = gnt1;
  assign p0.rsp_valid = hit0;
  assign p1.rsp_valid = hit1;
  assign p0.rsp_err   = hit0 & pipe.err;
  assign p1.rsp_err   = hit1 & pipe.err;
  assign p0.rsp_rdata = hit0 ? rd_ext : '0;
  assign p1.rsp_rdata = hit1 ? rd_ext : '0;
endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus randomized traffic checked
// against a byte-array memory model with its own round-robin bookkeeping.
module tb_dram_arbiter;
  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) p0_if ();
  dram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) p1_if ();

  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wr_data;
  logic          mem_wr_en;
  logic [3:0]    mem_wr_byte_en;
  logic [31:0]   mem_rd_data;

  dram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .p0(p0_if), .p1(p1_if),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .mem_wr_byte_en(mem_wr_byte_en), .mem_rd_data(mem_rd_data)
  );

  int checks = 0;
  int errors = 0;

  // RAM model with a bench-side preload path.
  logic [31:0]   ram [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [31:0]   pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_wr_en)
      for (int b = 0; b < 4; b++)
        if (mem_wr_byte_en[b]) ram[mem_addr][8*b +: 8] <= mem_wr_data[8*b +: 8];
    mem_rd_data <= ram[mem_addr];
  end

  logic [7:0] ref_mem [0:63];
  logic       model_prio;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    p0_if.req_valid = 0; p0_if.req_we = 0; p0_if.req_addr = '0;
    p0_if.req_size = 0; p0_if.req_unsigned = 0; p0_if.req_wdata = '0;
    p1_if.req_valid = 0; p1_if.req_we = 0; p1_if.req_addr = '0;
    p1_if.req_size = 0; p1_if.req_unsigned = 0; p1_if.req_wdata = '0;
  endtask

  task automatic set_req(input int port, input logic we, input logic [11:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata);
    if (port == 0) begin
      p0_if.req_valid = 1; p0_if.req_we = we; p0_if.req_addr = addr;
      p0_if.req_size = size; p0_if.req_unsigned = uns; p0_if.req_wdata = wdata;
    end else begin
      p1_if.req_valid = 1; p1_if.req_we = we; p1_if.req_addr = addr;
      p1_if.req_size = size; p1_if.req_unsigned = uns; p1_if.req_wdata = wdata;
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pl_addr = a; pl_data = d; pl_en = 1;
    tick();
    pl_en = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_req();
    tick();
    tick();
    rst = 0;
  endtask

  function automatic logic is_bad(input logic [11:0] a, input logic [1:0] sz);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_load(input logic [11:0] a, input logic [1:0] sz, input logic u);
    int i = int'(a[5:0]);
    logic [31:0] v;
    if (sz == 2'b00)      v = u ? {24'h0, ref_mem[i]} : {{24{ref_mem[i][7]}}, ref_mem[i]};
    else if (sz == 2'b01) v = u ? {16'h0, ref_mem[i+1], ref_mem[i]}
                                : {{16{ref_mem[i+1][7]}}, ref_mem[i+1], ref_mem[i]};
    else                  v = {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
    return v;
  endfunction

  task automatic test_reset();
    rst = 1;
    set_req(0, 1, 12'h010, 2'b10, 0, 32'hDEADBEEF);
    set_req(1, 0, 12'h014, 2'b10, 0, 32'h0);
    #2;
    checks++; if (p0_if.req_ready !== 1'b0 || p1_if.req_ready !== 1'b0) begin errors++;
      $display("FAIL reset_ready: got %b%b want 00", p0_if.req_ready, p1_if.req_ready); end
    checks++; if (mem_wr_en !== 1'b0 || mem_wr_byte_en !== 4'b0000) begin errors++;
      $display("FAIL reset_wr_gate: got en=%b be=%b want 0/0000", mem_wr_en, mem_wr_byte_en); end
    tick();
    checks++; if (p0_if.rsp_valid !== 1'b0 || p1_if.rsp_valid !== 1'b0 || p0_if.rsp_err !== 1'b0
                  || p0_if.rsp_rdata !== 32'h0) begin errors++;
      $display("FAIL reset_rsp: got v=%b%b err=%b rdata=%h want 0", p0_if.rsp_valid,
               p1_if.rsp_valid, p0_if.rsp_err, p0_if.rsp_rdata); end
    clear_req();
    rst = 0;
    tick();
  endtask

  task automatic test_load_word();
    preload(10'd4, 32'h8899AABB);
    set_req(0, 0, 12'h010, 2'b10, 0, 32'h0);
    #2;
    checks++; if (p0_if.req_ready !== 1'b1 || p1_if.req_ready !== 1'b0 || mem_addr !== 10'd4
                  || mem_wr_en !== 1'b0) begin errors++;
      $display("FAIL ldw_grant: got rdy=%b%b addr=%0d we=%b want 10/4/0", p0_if.req_ready,
               p1_if.req_ready, mem_addr, mem_wr_en); end
    tick();
    clear_req();
    checks++; if (p0_if.rsp_valid !== 1'b1 || p0_if.rsp_rdata !== 32'h8899AABB || p0_if.rsp_err !== 1'b0
                  || p1_if.rsp_valid !== 1'b0) begin errors++;
      $display("FAIL ldw_rsp: got v=%b rdata=%h err=%b want 1/8899aabb/0", p0_if.rsp_valid,
               p0_if.rsp_rdata, p0_if.rsp_err); end
    tick();
  endtask

  task automatic test_byte_lanes();
    logic [11:0] la [3] = '{12'h013, 12'h012, 12'h012};
    logic        lu [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] le [3] = '{32'h0000005A, 32'hFFFFFF99, 32'h00000099};
    set_req(1, 1, 12'h013, 2'b00, 0, 32'h1234565A);
    #2;
    checks++; if (p1_if.req_ready !== 1'b1 || mem_wr_byte_en !== 4'b1000 || mem_wr_data[31:24] !== 8'h5A
                  || mem_addr !== 10'd4 || mem_wr_en !== 1'b1) begin errors++;
      $display("FAIL stb_drive: got rdy=%b be=%b d=%h addr=%0d en=%b want 1/1000/5a../4/1",
               p1_if.req_ready, mem_wr_byte_en, mem_wr_data, mem_addr, mem_wr_en); end
    tick();
    clear_req();
    checks++; if (p1_if.rsp_valid !== 1'b1 || p1_if.rsp_rdata !== 32'h0 || p1_if.rsp_err !== 1'b0) begin
      errors++; $display("FAIL stb_rsp: got v=%b rdata=%h err=%b want 1/0/0", p1_if.rsp_valid,
                         p1_if.rsp_rdata, p1_if.rsp_err); end
    for (int i = 0; i < 3; i++) begin
      set_req(0, 0, la[i], 2'b00, lu[i], 32'h0);
      tick();
      clear_req();
      checks++; if (p0_if.rsp_valid !== 1'b1 || p0_if.rsp_rdata !== le[i]) begin errors++;
        $display("FAIL ldb_%0d: got v=%b rdata=%h want 1/%h", i, p0_if.rsp_valid, p0_if.rsp_rdata, le[i]); end
    end
    tick();
  endtask

  task automatic test_alternation();
    do_reset();
    set_req(0, 0, 12'h000, 2'b10, 0, 32'h0);
    set_req(1, 0, 12'h004, 2'b10, 0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      #2;
      checks++; if (p0_if.req_ready !== (i % 2 == 0) || p1_if.req_ready !== (i % 2 == 1)) begin errors++;
        $display("FAIL alt_grant_%0d: got rdy=%b%b want p%0d", i, p0_if.req_ready, p1_if.req_ready, i % 2); end
      tick();
      checks++; if (p0_if.rsp_valid !== (i % 2 == 0) || p1_if.rsp_valid !== (i % 2 == 1)) begin errors++;
        $display("FAIL alt_rsp_%0d: got v=%b%b want p%0d", i, p0_if.rsp_valid, p1_if.rsp_valid, i % 2); end
      #1;
    end
    clear_req();
    tick();
  endtask

  task automatic test_errors();
    logic        ew [3] = '{1'b0, 1'b1, 1'b0};
    logic [11:0] ea [3] = '{12'h011, 12'h006, 12'h000};
    logic [1:0]  es [3] = '{2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      set_req(0, ew[i], ea[i], es[i], 0, 32'hCAFEF00D);
      #2;
      checks++; if (p0_if.req_ready !== 1'b1 || mem_wr_en !== 1'b0 || mem_wr_byte_en !== 4'b0
                    || mem_addr !== 10'd0 || mem_wr_data !== 32'h0) begin errors++;
        $display("FAIL err_drive_%0d: got rdy=%b en=%b be=%b addr=%0d d=%h want 1/0/0/0/0", i,
                 p0_if.req_ready, mem_wr_en, mem_wr_byte_en, mem_addr, mem_wr_data); end
      tick();
      clear_req();
      checks++; if (p0_if.rsp_valid !== 1'b1 || p0_if.rsp_err !== 1'b1 || p0_if.rsp_rdata !== 32'h0) begin
        errors++; $display("FAIL err_rsp_%0d: got v=%b err=%b rdata=%h want 1/1/0", i,
                           p0_if.rsp_valid, p0_if.rsp_err, p0_if.rsp_rdata); end
    end
    tick();
  endtask

  task automatic test_reset_midop();
    set_req(0, 0, 12'h010, 2'b10, 0, 32'h0);
    tick();
    clear_req();
    rst = 1;
    #1;
    checks++; if (p0_if.rsp_valid !== 1'b0) begin errors++;
      $display("FAIL midrst_rsp: got v=%b want 0", p0_if.rsp_valid); end
    set_req(0, 1, 12'h010, 2'b10, 0, 32'h0BADF00D);
    set_req(1, 0, 12'h014, 2'b10, 0, 32'h0);
    #1;
    checks++; if (p0_if.req_ready !== 1'b0 || p1_if.req_ready !== 1'b0 || mem_wr_en !== 1'b0) begin errors++;
      $display("FAIL midrst_gate: got rdy=%b%b en=%b want 00/0", p0_if.req_ready, p1_if.req_ready, mem_wr_en); end
    tick();
    rst = 0;
    set_req(0, 0, 12'h010, 2'b10, 0, 32'h0);
    #2;
    checks++; if (p0_if.req_ready !== 1'b1 || p1_if.req_ready !== 1'b0) begin errors++;
      $display("FAIL midrst_prio: got rdy=%b%b want 10", p0_if.req_ready, p1_if.req_ready); end
    tick();
    clear_req();
    tick();
  endtask

  task automatic test_back_to_back();
    preload(10'd8, 32'h11223344);
    set_req(0, 1, 12'h022, 2'b01, 0, 32'h0000BEEF);
    #2;
    checks++; if (mem_wr_byte_en !== 4'b1100 || mem_wr_data[31:16] !== 16'hBEEF || mem_addr !== 10'd8) begin
      errors++; $display("FAIL b2b_store: got be=%b d=%h addr=%0d want 1100/beef..../8",
                         mem_wr_byte_en, mem_wr_data, mem_addr); end
    tick();
    clear_req();
    set_req(1, 0, 12'h020, 2'b10, 0, 32'h0);
    tick();
    clear_req();
    checks++; if (p1_if.rsp_valid !== 1'b1 || p1_if.rsp_rdata !== 32'hBEEF3344) begin errors++;
      $display("FAIL b2b_load: got v=%b rdata=%h want 1/beef3344", p1_if.rsp_valid, p1_if.rsp_rdata); end
    tick();
  endtask

  task automatic test_random();
    logic        rv [2];
    logic        rw [2];
    logic [11:0] ra [2];
    logic [1:0]  rs [2];
    logic        ru [2];
    logic [31:0] rd [2];
    logic        exp_v = 0, exp_port = 0, exp_err = 0;
    logic [31:0] exp_data = '0;
    int g;
    for (int w = 0; w < 16; w++) begin
      logic [31:0] d = $urandom;
      preload(AW'(w), d);
      for (int b = 0; b < 4; b++) ref_mem[4*w+b] = d[8*b +: 8];
    end
    do_reset();
    model_prio = 0;
    for (int cyc = 0; cyc <= 400; cyc++) begin
      checks++; if (p0_if.rsp_valid !== (exp_v && !exp_port) || p1_if.rsp_valid !== (exp_v && exp_port)) begin
        errors++; $display("FAIL rnd_rsp_valid@%0d: got %b%b want v=%b port=%b", cyc,
                           p0_if.rsp_valid, p1_if.rsp_valid, exp_v, exp_port); end
      if (exp_v) begin
        checks++;
        if (( exp_port && (p1_if.rsp_rdata !== exp_data || p1_if.rsp_err !== exp_err)) ||
            (!exp_port && (p0_if.rsp_rdata !== exp_data || p0_if.rsp_err !== exp_err))) begin
          errors++; $display("FAIL rnd_rsp_data@%0d: got %h/%b %h/%b want p%0d %h/%b", cyc,
                             p0_if.rsp_rdata, p0_if.rsp_err, p1_if.rsp_rdata, p1_if.rsp_err,
                             exp_port, exp_data, exp_err); end
      end
      if (cyc == 400) break;
      clear_req();
      for (int p = 0; p < 2; p++) begin
        rv[p] = ($urandom_range(0, 3) != 0);
        rw[p] = 1'($urandom_range(0, 1));
        ra[p] = 12'($urandom_range(0, 63));
        rs[p] = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        ru[p] = 1'($urandom_range(0, 1));
        rd[p] = $urandom;
        if (rv[p]) set_req(p, rw[p], ra[p], rs[p], ru[p], rd[p]);
      end
      g = -1;
      if (rv[0] && rv[1]) g = int'(model_prio);
      else if (rv[0])     g = 0;
      else if (rv[1])     g = 1;
      #2;
      checks++; if (p0_if.req_ready !== (g == 0) || p1_if.req_ready !== (g == 1)) begin errors++;
        $display("FAIL rnd_grant@%0d: got %b%b want grant %0d", cyc, p0_if.req_ready, p1_if.req_ready, g); end
      exp_v = (g >= 0);
      if (g >= 0) begin
        exp_port = (g == 1);
        exp_err  = is_bad(ra[g], rs[g]);
        exp_data = (exp_err || rw[g]) ? 32'h0 : ref_load(ra[g], rs[g], ru[g]);
        checks++; if (mem_wr_en !== (rw[g] && !exp_err)) begin errors++;
          $display("FAIL rnd_wr_en@%0d: got %b want %b", cyc, mem_wr_en, rw[g] && !exp_err); end
        if (rw[g] && !exp_err) begin
          int n = (rs[g] == 2'b00) ? 1 : (rs[g] == 2'b01) ? 2 : 4;
          for (int b = 0; b < n; b++) ref_mem[int'(ra[g][5:0]) + b] = rd[g][8*b +: 8];
        end
        model_prio = (g == 0);
      end else begin
        checks++; if (mem_wr_en !== 1'b0) begin errors++;
          $display("FAIL rnd_idle_wr@%0d: got %b want 0", cyc, mem_wr_en); end
      end
      tick();
    end
    clear_req();
    tick();
  endtask

  initial begin
    rst = 1;
    clear_req();
    test_reset();
    test_load_word();
    test_byte_lanes();
    test_alternation();
    test_errors();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
